point_motor_scheduler: RTL

Sequences the point (switch) motor drives of the train control system. The interlocking logic produces a desired position per point, but all point motors share one supply that can energise only one coil at a time. This block arbitrates pending position changes round-robin, drives one timed coil pulse at a time, and enforces a recovery gap between pulses. It tracks the last completed position of every point and sits between the route/interlock logic and the GPIO coil drivers.

---
 rtl/point_motor_scheduler_if.sv | 36 +++
 rtl/point_motor_scheduler.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/point_motor_scheduler_if.sv
// Bundle between interlock logic and the point motor scheduler:
// requested positions/hold in, coil drives and status out.
interface point_motor_scheduler_if #(
  parameter int NUM_POINTS = 8
);
  logic [NUM_POINTS-1:0] target;
  logic                  hold;
  logic [NUM_POINTS-1:0] coil_normal;
  logic [NUM_POINTS-1:0] coil_reverse;
  logic [NUM_POINTS-1:0] position;
  logic [NUM_POINTS-1:0] pending;
  logic                  busy;
  logic                  throw_done;

  modport master (
    output target,
    output hold,
    input  coil_normal,
    input  coil_reverse,
    input  position,
    input  pending,
    input  busy,
    input  throw_done
  );

  modport slave (
    input  target,
    input  hold,
    output coil_normal,
    output coil_reverse,
    output position,
    output pending,
    output busy,
    output throw_done
  );
endinterface

// File: rtl/point_motor_scheduler.sv
// Round-robin, one-coil-at-a-time point motor sequencer with recovery gap.
// Define POWERUP_SYNC_EN to throw every point once after reset.
module point_motor_scheduler #(
  parameter int NUM_POINTS   = 8,
  parameter int PULSE_CYCLES = 10_000_000,
  parameter int GAP_CYCLES   = 5_000_000
) (
  input logic                    CLOCK_50,
  input logic                    RESET_N,
  point_motor_scheduler_if.slave bus
);

  localparam int IW   = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ?
                        PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_POINTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         idx;
  logic                  dir;
  logic [NUM_POINTS-1:0] coil_n;
  logic [NUM_POINTS-1:0] coil_r;
  logic [NUM_POINTS-1:0] pos;
  logic                  busy_q;
  logic                  done_q;

  logic [NUM_POINTS-1:0] pend;
  logic [IW-1:0]         sel;
  logic [NUM_POINTS-1:0] sel_hot;
  logic                  pulse_end;

  assign pulse_end = (state == PULSE) && (cnt == P_LAST);

`ifdef POWERUP_SYNC_EN
  logic [NUM_POINTS-1:0] sync_mask;

  // A point leaves the sync set only when its throw actually completes.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sync_mask <= '1;
    end else if (pulse_end) begin
      sync_mask[idx] <= 1'b0;
    end
  end
`else
  logic [NUM_POINTS-1:0] sync_mask;
  assign sync_mask = '0;
`endif

  assign pend = (bus.target ^ pos) | sync_mask;

  // First pending point at or above the pointer, wrapping past the top.
  always_comb begin
    int   j;
    logic found;
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_POINTS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_POINTS) j = j - NUM_POINTS;
      if (!found && pend[IW'(j)]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  assign sel_hot = NUM_POINTS'(1) << sel;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= '0;
      idx    <= '0;
      dir    <= 1'b0;
      coil_n <= '0;
      coil_r <= '0;
      pos    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bus.hold && (|pend)) begin
            idx    <= sel;
            dir    <= bus.target[sel];
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= PULSE;
            if (bus.target[sel]) coil_r <= sel_hot;
            else                 coil_n <= sel_hot;
          end
        end
        PULSE: begin
          if (cnt == P_LAST) begin
            coil_n   <= '0;
            coil_r   <= '0;
            pos[idx] <= dir;
            done_q   <= 1'b1;
            ptr      <= (idx == I_LAST) ? '0 : idx + IW'(1);
            cnt      <= '0;
            state    <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == G_LAST) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          coil_n <= '0;
          coil_r <= '0;
          busy_q <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.coil_normal  = coil_n;
  assign bus.coil_reverse = coil_r;
  assign bus.position     = pos;
  assign bus.pending      = pend;
  assign bus.busy         = busy_q;
  assign bus.throw_done   = done_q;

endmodule
